// File: rtl/alu_sequencer.sv
// Single-issue ALU sequencer with a valid/ready request and response.
// Add, sub, logic and compare ops take one EXEC cycle. Shifts walk one bit
// position per EXEC cycle. The result is held in DONE until the consumer
// takes it.
module alu_sequencer (
    input  logic        clk,
    input  logic        rstN,
    input  logic        reqValid,
    output logic        reqReady,
    input  logic [31:0] opA,
    input  logic [31:0] opB,
    input  logic [3:0]  aluOutSel,
    output logic        respValid,
    input  logic        respReady,
    output logic [31:0] aluOut,
    output logic        illegalOp,
    output logic        busy,
    output logic [15:0] opCount
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SUB  = 4'b0001;
    localparam logic [3:0] OP_XOR  = 4'b0010;
    localparam logic [3:0] OP_OR   = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_SLT  = 4'b0101;
    localparam logic [3:0] OP_SLTU = 4'b0110;
    localparam logic [3:0] OP_SLL  = 4'b0111;
    localparam logic [3:0] OP_SRL  = 4'b1000;

    state_t      r_state;
    logic [31:0] r_acc;
    logic [31:0] r_opB;
    logic [3:0]  r_sel;
    logic [4:0]  r_cnt;
    logic [31:0] r_aluOut;
    logic        r_illegal;
    logic [15:0] r_opCount;

    logic [31:0] w_result;
    logic        w_illegal;
    logic        w_isShift;
    logic [31:0] w_shifted;

    // Single-cycle result for the non-shift ops; unknown opcodes flag illegal with a zero result
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        case (r_sel)
            OP_ADD:  w_result = r_acc + r_opB;
            OP_SUB:  w_result = r_acc - r_opB;
            OP_XOR:  w_result = r_acc ^ r_opB;
            OP_OR:   w_result = r_acc | r_opB;
            OP_AND:  w_result = r_acc & r_opB;
            OP_SLT:  w_result = {31'd0, $signed(r_acc) < $signed(r_opB)};
            OP_SLTU: w_result = {31'd0, r_acc < r_opB};
            OP_SLL,
            OP_SRL:  w_result = r_acc;
            default: w_illegal = 1'b1;
        endcase
    end

    assign w_isShift = (r_sel == OP_SLL) || (r_sel == OP_SRL);
    assign w_shifted = (r_sel == OP_SLL) ? {r_acc[30:0], 1'b0} : {1'b0, r_acc[31:1]};

    // Sequencer FSM: capture on request, iterate or compute in EXEC, hold in DONE
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            r_state   <= IDLE;
            r_acc     <= '0;
            r_opB     <= '0;
            r_sel     <= '0;
            r_cnt     <= '0;
            r_aluOut  <= '0;
            r_illegal <= 1'b0;
            r_opCount <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (reqValid) begin
                        r_acc   <= opA;
                        r_opB   <= opB;
                        r_sel   <= aluOutSel;
                        r_cnt   <= opB[4:0];
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_isShift) begin
                        if (r_cnt == 5'd0) begin
                            // Zero shift amount passes the operand straight through
                            r_aluOut  <= r_acc;
                            r_illegal <= 1'b0;
                            r_state   <= DONE;
                        end else begin
                            r_acc <= w_shifted;
                            r_cnt <= r_cnt - 5'd1;
                            if (r_cnt == 5'd1) begin
                                r_aluOut  <= w_shifted;
                                r_illegal <= 1'b0;
                                r_state   <= DONE;
                            end
                        end
                    end else begin
                        r_aluOut  <= w_result;
                        r_illegal <= w_illegal;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (respReady) begin
                        r_opCount <= r_opCount + 16'd1;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign reqReady  = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign respValid = (r_state == DONE);
    assign aluOut    = r_aluOut;
    assign illegalOp = r_illegal;
    assign opCount   = r_opCount;

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer. Inputs are driven and outputs are
// sampled on the falling clock edge.
module tb_alu_sequencer;

    logic        clk = 1'b0;
    logic        rstN;
    logic        reqValid;
    logic        reqReady;
    logic [31:0] opA;
    logic [31:0] opB;
    logic [3:0]  aluOutSel;
    logic        respValid;
    logic        respReady;
    logic [31:0] aluOut;
    logic        illegalOp;
    logic        busy;
    logic [15:0] opCount;

    int n_pass  = 0;
    int n_total = 0;
    int lat;
    int seen;
    logic [15:0] exp_cnt;

    alu_sequencer dut (
        .clk       (clk),
        .rstN      (rstN),
        .reqValid  (reqValid),
        .reqReady  (reqReady),
        .opA       (opA),
        .opB       (opB),
        .aluOutSel (aluOutSel),
        .respValid (respValid),
        .respReady (respReady),
        .aluOut    (aluOut),
        .illegalOp (illegalOp),
        .busy      (busy),
        .opCount   (opCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // Issue one request from a falling edge and wait for respValid.
    // The operands are scrambled right after acceptance.
    task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic [3:0] s,
                         output int l);
        chk("reqReady_before_req", {31'd0, reqReady}, 32'd1);
        reqValid  = 1'b1;
        opA       = a;
        opB       = b;
        aluOutSel = s;
        @(negedge clk);
        reqValid  = 1'b0;
        opA       = ~a;
        opB       = ~b;
        aluOutSel = s ^ 4'h5;
        l = 0;
        while (!respValid && l < 100) begin
            @(negedge clk);
            l++;
        end
    endtask

    // With respReady high, the response retires on the next edge
    task automatic finish_op;
        @(negedge clk);
        exp_cnt = exp_cnt + 16'd1;
        chk("respValid_one_cycle", {31'd0, respValid}, 32'd0);
        chk("opCount", {16'd0, opCount}, {16'd0, exp_cnt});
    endtask

    initial begin
        rstN      = 1'b1;
        reqValid  = 1'b1;
        opA       = 32'hDEADBEEF;
        opB       = 32'h1;
        aluOutSel = 4'h0;
        respReady = 1'b1;
        exp_cnt   = 16'd0;
        #1 rstN = 1'b0;
        // The request is held high during reset and must not be accepted
        repeat (3) @(negedge clk);
        chk("rst_reqReady", {31'd0, reqReady}, 32'd1);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_respValid", {31'd0, respValid}, 32'd0);
        chk("rst_aluOut", aluOut, 32'd0);
        chk("rst_illegal", {31'd0, illegalOp}, 32'd0);
        chk("rst_opCount", {16'd0, opCount}, 32'd0);
        reqValid = 1'b0;
        rstN     = 1'b1;
        @(negedge clk);

        // add with overflow
        do_op(32'h7FFFFFFF, 32'h1, 4'b0000, lat);
        chk("add_lat", 32'(lat), 32'd1);
        chk("add_out", aluOut, 32'h80000000);
        chk("add_illegal", {31'd0, illegalOp}, 32'd0);
        finish_op();

        do_op(32'd5, 32'd7, 4'b0001, lat);
        chk("sub_out", aluOut, 32'hFFFFFFFE);
        finish_op();
        do_op(32'hA5A5A5A5, 32'hFFFF0000, 4'b0010, lat);
        chk("xor_out", aluOut, 32'h5A5AA5A5);
        finish_op();
        do_op(32'h0F0F0000, 32'h000000F0, 4'b0011, lat);
        chk("or_out", aluOut, 32'h0F0F00F0);
        finish_op();
        do_op(32'hFF00FF00, 32'h0FF00FF0, 4'b0100, lat);
        chk("and_out", aluOut, 32'h0F000F00);
        finish_op();
        do_op(32'hFFFFFFFF, 32'h1, 4'b0101, lat);
        chk("slt_out", aluOut, 32'd1);
        finish_op();
        do_op(32'hFFFFFFFF, 32'h1, 4'b0110, lat);
        chk("sltu_out", aluOut, 32'd0);
        finish_op();

        // shifts
        do_op(32'h00000001, 32'd31, 4'b0111, lat);
        chk("sll31_lat", 32'(lat), 32'd31);
        chk("sll31_out", aluOut, 32'h80000000);
        finish_op();
        do_op(32'hF0000000, 32'h24, 4'b1000, lat);
        chk("srl4_lat", 32'(lat), 32'd4);
        chk("srl4_out", aluOut, 32'h0F000000);
        finish_op();
        do_op(32'h12345678, 32'h20, 4'b0111, lat);
        chk("sll0_lat", 32'(lat), 32'd1);
        chk("sll0_out", aluOut, 32'h12345678);
        finish_op();

        // backpressure: hold the response for 5 cycles while operands toggle
        respReady = 1'b0;
        do_op(32'd3, 32'd4, 4'b0000, lat);
        for (int i = 0; i < 5; i++) begin
            opA = 32'(i) * 32'h11111111;
            opB = ~opA;
            @(negedge clk);
            chk("bp_out", aluOut, 32'd7);
            chk("bp_valid", {31'd0, respValid}, 32'd1);
            chk("bp_reqReady", {31'd0, reqReady}, 32'd0);
        end
        respReady = 1'b1;
        finish_op();
        chk("bp_idle", {31'd0, busy}, 32'd0);

        // illegal opcode, then a legal op must clear the flag
        do_op(32'h1234, 32'h1, 4'b1010, lat);
        chk("ill_lat", 32'(lat), 32'd1);
        chk("ill_out", aluOut, 32'd0);
        chk("ill_flag", {31'd0, illegalOp}, 32'd1);
        finish_op();
        do_op(32'd1, 32'd1, 4'b0000, lat);
        chk("ill_clear", {31'd0, illegalOp}, 32'd0);
        chk("ill_clear_out", aluOut, 32'd2);
        finish_op();

        // reset in the middle of a 20-step shift
        reqValid  = 1'b1;
        opA       = 32'h1;
        opB       = 32'd20;
        aluOutSel = 4'b0111;
        @(negedge clk);
        reqValid = 1'b0;
        repeat (10) @(negedge clk);
        chk("abort_busy", {31'd0, busy}, 32'd1);
        #2 rstN = 1'b0;
        #1;
        chk("abort_busy_rst", {31'd0, busy}, 32'd0);
        chk("abort_respValid", {31'd0, respValid}, 32'd0);
        chk("abort_reqReady", {31'd0, reqReady}, 32'd1);
        chk("abort_aluOut", aluOut, 32'd0);
        chk("abort_illegal", {31'd0, illegalOp}, 32'd0);
        chk("abort_opCount", {16'd0, opCount}, 32'd0);
        @(negedge clk);
        rstN = 1'b1;
        exp_cnt = 16'd0;
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (respValid) seen++;
        end
        chk("abort_no_resp", 32'(seen), 32'd0);
        chk("abort_opCount_after", {16'd0, opCount}, 32'd0);

        // counter wrap: preload to 0xFFFE, then two more handshakes
        force dut.r_opCount = 16'hFFFE;
        @(negedge clk);
        release dut.r_opCount;
        exp_cnt = 16'hFFFE;
        do_op(32'd1, 32'd2, 4'b0000, lat);
        finish_op();
        chk("wrap_ffff", {16'd0, opCount}, 32'h0000FFFF);
        do_op(32'd1, 32'd2, 4'b0000, lat);
        finish_op();
        chk("wrap_zero", {16'd0, opCount}, 32'h00000000);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 The block SHALL use one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  sole clock, all state updates on rising edge.
REQ-003 rstN  input  1  asynchronous active-low reset.
REQ-004 reqValid  input  1  requester presents an operation.
REQ-005 reqReady  output  1  block can accept an operation; equals (state==IDLE).
REQ-006 opA  input  32  first operand, sampled on request handshake.
REQ-007 opB  input  32  second operand or shift amount, sampled on request handshake.
REQ-008 aluOutSel  input  4  operation select, sampled on request handshake.
REQ-009 respValid  output  1  aluOut holds a completed result.
REQ-010 respReady  input  1  consumer accepts the result.
REQ-011 aluOut  output  32  registered result.
REQ-012 illegalOp  output  1  result belongs to an unsupported aluOutSel; qualified by respValid.
REQ-013 busy  output  1  high whenever state is not IDLE.
REQ-014 opCount  output  16  number of completed response handshakes, wraps 0xFFFF->0x0000.

Function
REQ-015 The FSM SHALL have exactly three states: IDLE, EXEC, DONE.
REQ-016 Request handshake = reqValid && reqReady at a rising edge; it captures opA, opB, aluOutSel, loads acc=opA, cnt=opB[4:0], and moves IDLE->EXEC.
REQ-017 Opcodes: 0000 add, 0001 sub (opA-opB), 0010 xor, 0011 or, 0100 and, 0101 signed less-than, 0110 unsigned less-than, 0111 shift-left logical, 1000 shift-right logical; arithmetic is modulo 2^32, compare results are 32'd1 or 32'd0.
REQ-018 Non-shift ops: EXEC lasts one cycle; next edge loads aluOut=f(opA,opB), illegalOp=0, EXEC->DONE.
REQ-019 Shift ops SHALL execute iteratively, one bit per EXEC cycle, using only cnt=opB[4:0]; opB[31:5] ignored.
REQ-020 Shift with cnt==0: next edge loads aluOut=acc (unchanged opA), EXEC->DONE.
REQ-021 Shift with cnt>=1: each edge shifts acc by one bit (zero fill) and decrements cnt; the edge where cnt==1 loads aluOut with the final shifted value and moves EXEC->DONE.
REQ-022 Latency from request handshake edge to first cycle with respValid=1: max(1, cnt) cycles for shifts, 1 cycle for all other ops.
REQ-023 Opcodes 1001-1111: one EXEC cycle, aluOut=0, illegalOp=1, EXEC->DONE.
REQ-024 DONE: respValid=1; aluOut and illegalOp held stable until respValid && respReady at an edge, then DONE->IDLE and opCount increments.
REQ-025 respValid SHALL be 0 in IDLE and EXEC; reqReady SHALL be 0 in EXEC and DONE, so at most one operation is in flight.
REQ-026 Input changes on opA/opB/aluOutSel after the request handshake SHALL not affect the in-flight result.
REQ-027 respReady held high before DONE SHALL complete the handshake on the first DONE edge (respValid high for exactly one cycle).
REQ-028 First request accepted no earlier than the edge after the DONE->IDLE edge.

Reset
REQ-029 rstN low SHALL immediately force state=IDLE, respValid=0, busy=0, illegalOp=0, aluOut=0, opCount=0, acc=0, cnt=0; reqReady reads 1.
REQ-030 reqValid asserted while rstN is low SHALL not be accepted.
REQ-031 Reset asserted in EXEC or DONE SHALL abort the operation with no response and no opCount increment.

Verification
REQ-032 add: opA=0x7FFFFFFF, opB=1, sel=0000, respReady=1 -> respValid 1 cycle after accept, aluOut=0x80000000, illegalOp=0, opCount=1.
REQ-033 compares: opA=0xFFFFFFFF, opB=1, sel=0101 -> aluOut=1; same operands sel=0110 -> aluOut=0.
REQ-034 shifts: opA=0x00000001, opB=31, sel=0111 -> respValid 31 cycles after accept, aluOut=0x80000000; opA=0xF0000000, opB=0x24 (cnt=4), sel=1000 -> 4 cycles, aluOut=0x0F000000; opB=0 -> 1 cycle, aluOut=opA.
REQ-035 backpressure: respReady=0 for 5 cycles in DONE, opA/opB toggled meanwhile -> aluOut, respValid stable, reqReady=0; respReady=1 -> IDLE next edge, opCount+1.
REQ-036 illegal/reset: sel=1010 -> aluOut=0, illegalOp=1 after 1 cycle; shift with cnt=20, rstN pulsed low at cycle 10 -> all outputs reset values, no respValid, opCount=0.
REQ-037 wrap: preload 65535 completed handshakes -> opCount=0xFFFF; one more -> 0x0000.
